// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential word fetch from a reset PC, one outstanding
// memory read at a time, a small instruction FIFO toward the decoder, and a
// PC redirect that flushes both the FIFO and any in-flight fetch.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        mem_rsp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_err
);

   // Pointer width never collapses to zero bits, even for a single-entry FIFO.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        err;
   } entry_t;

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_addr_q, req_addr_d;
   logic          req_valid_q, req_valid_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic          drop_q, drop_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   entry_t        fifo_q [DEPTH];
   entry_t        fifo_d [DEPTH];

   logic          req_fire;
   logic          rsp_fire;
   logic          push;
   logic          pop;
   logic [CW-1:0] count_pushed;
   logic          credit_idle;
   logic          credit_resp;
   entry_t        head;

   // Low address bits of a redirect target are discarded by design.
   logic          redirect_pc_unused;
   assign redirect_pc_unused = ^redirect_pc[1:0];

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (DEPTH == 1) return '0;
      return p + AW'(1);
   endfunction

   assign req_fire     = (state_q == REQ) && mem_req_ready;
   assign rsp_fire     = (state_q == RESP) && mem_rsp_valid;
   // A response landing in the redirect cycle belongs to the old stream.
   assign push         = rsp_fire && !drop_q && !redirect_valid;
   assign pop          = (count_q != '0) && inst_ready;
   assign count_pushed = count_q + CW'(push);
   // A new request reserves a FIFO slot up front, so credit ignores this cycle's pop.
   assign credit_idle  = count_q < CW'(DEPTH);
   assign credit_resp  = redirect_valid || (count_pushed < CW'(DEPTH));

   // Fetch sequencer next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (credit_idle && !redirect_valid) state_d = REQ;
         end
         REQ: begin
            if (mem_req_ready) state_d = RESP;
         end
         RESP: begin
            if (mem_rsp_valid) state_d = credit_resp ? REQ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Fetch PC, request address, in-flight PC and drop flag; redirect overrides all.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      drop_d     = drop_q;
      if (req_fire) begin
         resp_pc_d = req_addr_q;
         // A stale request must not advance the redirected PC.
         if (!drop_q) fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_fire) drop_d = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         // Only mark a drop if a response is still owed after this cycle.
         if ((state_q == REQ) || ((state_q == RESP) && !mem_rsp_valid)) drop_d = 1'b1;
      end
      // An offered request keeps its address until the memory takes it.
      req_addr_d  = ((state_q == REQ) && !mem_req_ready) ? req_addr_q : fetch_pc_d;
      req_valid_d = (state_d == REQ);
   end

   // Instruction FIFO bookkeeping; a redirect empties it outright.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q] = '{pc: resp_pc_q, data: mem_rsp_data, err: mem_rsp_err};
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
      if (redirect_valid) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         req_addr_q  <= RESET_PC;
         req_valid_q <= 1'b0;
         resp_pc_q   <= '0;
         drop_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         req_addr_q  <= req_addr_d;
         req_valid_q <= req_valid_d;
         resp_pc_q   <= resp_pc_d;
         drop_q      <= drop_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         fifo_q      <= fifo_d;
      end
   end

   assign head          = fifo_q[rd_ptr_q];
   assign mem_req_valid = req_valid_q;
   assign mem_req_addr  = req_addr_q;
   assign inst_valid    = (count_q != '0);
   // Head fields read as zero when nothing valid is presented.
   assign inst          = inst_valid ? head.data : '0;
   assign inst_pc       = inst_valid ? head.pc   : '0;
   assign inst_err      = inst_valid ? head.err  : 1'b0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized run against a
// stream-level reference model (expected PC stream, memory content function).
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_err;

   always #5 clk = ~clk;

   ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .mem_rsp_err    (mem_rsp_err),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_err       (inst_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus knobs
   int unsigned ready_pct, iready_pct, redir_pct, delay_min, delay_max;
   logic        err_directed;
   logic        force_redir;
   logic [31:0] force_redir_pc;

   // reference model state
   logic [31:0] exp_pc;
   logic        rsp_pending;
   logic [31:0] rsp_addr;
   int unsigned rsp_wait;
   logic        prev_stall, prev_redir, prev_hold, prev_err;
   logic [31:0] prev_addr, prev_pc, prev_inst;
   logic [31:0] acc_q [$];
   logic [31:0] pop_q [$];
   logic        pop_err_q [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic err_of(input logic [31:0] a);
      if (err_directed) return (a == 32'h8000_0004);
      return a[3] ^ a[6];
   endfunction

   task automatic set_knobs(input int unsigned rp, input int unsigned ip, input int unsigned dp,
                            input int unsigned dmin, input int unsigned dmax);
      ready_pct  = rp;
      iready_pct = ip;
      redir_pct  = dp;
      delay_min  = dmin;
      delay_max  = dmax;
   endtask

   task automatic model_reset();
      exp_pc      = RESET_PC;
      rsp_pending = 1'b0;
      rsp_wait    = 0;
      prev_stall  = 1'b0;
      prev_redir  = 1'b0;
      prev_hold   = 1'b0;
      force_redir = 1'b0;
      acc_q.delete();
      pop_q.delete();
      pop_err_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
      check_eq({tag, "_req_addr"},  mem_req_addr, RESET_PC);
      check_eq({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
      check_eq({tag, "_inst"},      inst, 32'd0);
      check_eq({tag, "_inst_pc"},   inst_pc, 32'd0);
      check_eq({tag, "_inst_err"},  32'(inst_err), 32'd0);
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_req_ready  = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
      mem_rsp_err    = 1'b0;
      inst_ready     = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
   endtask

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      case ($urandom_range(0, 2))
         0:       t = 32'h8000_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
         1:       t = 32'hFFFF_FFF0 | $urandom_range(0, 15);
         default: t = $urandom();
      endcase
      return t;
   endfunction

   // One clock cycle, entered and left at a falling edge.
   task automatic tick();
      logic acc, pop;
      if (prev_stall) begin
         check_eq("req_hold_valid", 32'(mem_req_valid), 32'd1);
         check_eq("req_hold_addr", mem_req_addr, prev_addr);
      end
      if (prev_redir) begin
         check_eq("flush_after_redirect", 32'(inst_valid), 32'd0);
      end else if (prev_hold) begin
         check_eq("inst_hold_valid", 32'(inst_valid), 32'd1);
         check_eq("inst_hold_pc", inst_pc, prev_pc);
         check_eq("inst_hold_data", inst, prev_inst);
         check_eq("inst_hold_err", 32'(inst_err), 32'(prev_err));
      end
      if (mem_req_valid) begin
         check_eq("single_outstanding", 32'(rsp_pending), 32'd0);
         check_eq("req_aligned", 32'(mem_req_addr[1:0]), 32'd0);
      end

      if (force_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_redir_pc;
         force_redir    = 1'b0;
      end else if ($urandom_range(0, 99) < redir_pct) begin
         redirect_valid = 1'b1;
         redirect_pc    = pick_target();
      end else begin
         redirect_valid = 1'b0;
         redirect_pc    = $urandom();
      end
      mem_req_ready = ($urandom_range(0, 99) < ready_pct);
      inst_ready    = redirect_valid ? 1'b0 : ($urandom_range(0, 99) < iready_pct);
      if (rsp_pending && rsp_wait == 0) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = data_of(rsp_addr);
         mem_rsp_err   = err_of(rsp_addr);
      end else begin
         // unsolicited responses outside the response phase must be ignored
         mem_rsp_valid = !rsp_pending && ($urandom_range(0, 9) == 0);
         mem_rsp_data  = $urandom();
         mem_rsp_err   = 1'($urandom_range(0, 1));
      end

      acc = mem_req_valid && mem_req_ready;
      pop = inst_valid && inst_ready;
      if (pop) begin
         check_eq("pop_pc", inst_pc, exp_pc);
         check_eq("pop_inst", inst, data_of(exp_pc));
         check_eq("pop_err", 32'(inst_err), 32'(err_of(exp_pc)));
         pop_q.push_back(inst_pc);
         pop_err_q.push_back(inst_err);
         exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};

      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_addr;
      prev_redir = redirect_valid;
      prev_hold  = inst_valid && !inst_ready;
      prev_pc    = inst_pc;
      prev_inst  = inst;
      prev_err   = inst_err;

      if (rsp_pending && mem_rsp_valid) rsp_pending = 1'b0;
      else if (rsp_pending) rsp_wait = rsp_wait - 1;
      if (acc) begin
         rsp_pending = 1'b1;
         rsp_addr    = mem_req_addr;
         rsp_wait    = $urandom_range(delay_max, delay_min);
         acc_q.push_back(mem_req_addr);
      end
      @(negedge clk);
   endtask

   task automatic wait_pending(input string tag);
      int guard = 0;
      while (!rsp_pending && guard < 20) begin
         tick();
         guard++;
      end
      check_eq(tag, 32'(rsp_pending), 32'd1);
   endtask

   initial begin
      int n0;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_req_ready  = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
      mem_rsp_err    = 1'b0;
      inst_ready     = 1'b0;
      force_redir    = 1'b0;
      force_redir_pc = '0;
      err_directed   = 1'b1;
      #1;

      // decoder stalled: FIFO fills to two entries, then fetching resumes at +8
      set_knobs(100, 0, 0, 0, 0);
      do_reset();
      repeat (12) tick();
      check_eq("fill_accepts", 32'(acc_q.size()), 32'd2);
      check_eq("fill_req_idle", 32'(mem_req_valid), 32'd0);
      check_eq("fill_inst_valid", 32'(inst_valid), 32'd1);
      check_eq("fill_head_pc", inst_pc, 32'h8000_0000);
      set_knobs(100, 100, 0, 0, 0);
      repeat (12) tick();
      check_eq("seq_req0", acc_q[0], 32'h8000_0000);
      check_eq("seq_req1", acc_q[1], 32'h8000_0004);
      check_eq("seq_req2", acc_q[2], 32'h8000_0008);

      // memory not ready: request held without advancing the fetch PC
      set_knobs(0, 100, 0, 0, 0);
      do_reset();
      repeat (4) tick();
      check_eq("stall_valid", 32'(mem_req_valid), 32'd1);
      check_eq("stall_addr", mem_req_addr, 32'h8000_0000);
      set_knobs(100, 100, 0, 0, 0);
      repeat (5) tick();
      check_eq("stall_acc0", acc_q[0], 32'h8000_0000);
      check_eq("stall_acc1", acc_q[1], 32'h8000_0004);

      // redirect while a response is outstanding
      set_knobs(100, 100, 0, 3, 3);
      do_reset();
      wait_pending("redir_reach_resp");
      n0             = pop_q.size();
      force_redir    = 1'b1;
      force_redir_pc = 32'h8000_1003;
      tick();
      set_knobs(100, 100, 0, 0, 0);
      repeat (20) tick();
      check_eq("redir_first_pc", pop_q[n0], 32'h8000_1000);

      // access fault on the second response only
      set_knobs(100, 100, 0, 0, 0);
      do_reset();
      repeat (16) tick();
      check_eq("err_pop0", 32'(pop_err_q[0]), 32'd0);
      check_eq("err_pop1", 32'(pop_err_q[1]), 32'd1);
      check_eq("err_pop1_pc", pop_q[1], 32'h8000_0004);
      check_eq("err_pop2", 32'(pop_err_q[2]), 32'd0);
      check_eq("err_pop2_pc", pop_q[2], 32'h8000_0008);

      // reset asserted mid-response, stale response presented after release
      set_knobs(100, 100, 0, 2, 2);
      do_reset();
      wait_pending("rst_reach_resp");
      rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      @(negedge clk);
      rst           = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom();
      mem_rsp_err   = 1'b1;
      mem_req_ready = 1'b0;
      inst_ready    = 1'b1;
      @(negedge clk);
      check_eq("rst_first_req_valid", 32'(mem_req_valid), 32'd1);
      check_eq("rst_first_req_addr", mem_req_addr, RESET_PC);
      check_eq("rst_no_stale_inst", 32'(inst_valid), 32'd0);
      set_knobs(100, 100, 0, 0, 0);
      repeat (10) tick();
      check_eq("rst_acc0", acc_q[0], RESET_PC);
      check_eq("rst_pop0", pop_q[0], RESET_PC);

      // randomized run against the stream model
      err_directed = 1'b0;
      set_knobs(70, 60, 3, 0, 3);
      do_reset();
      repeat (3000) tick();
      set_knobs(100, 100, 0, 0, 1);
      n0 = pop_q.size();
      repeat (40) tick();
      check_eq("drain_progress", 32'(pop_q.size() > n0 + 5), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
